// File: rtl/synchronous_d_ff_if.sv
`default_nettype none
// ============================================================================
// Module      : synchronous_d_ff_if
// Description : Data bundle for the two-stage D flip-flop chain (D in, Q1/Q2 out).
// Revision    : 1.0 - initial release
// ============================================================================
interface synchronous_d_ff_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q1;
    logic [WIDTH-1:0] Q2;

    modport master (
        output D,
        input  Q1,
        input  Q2
    );

    modport slave (
        input  D,
        output Q1,
        output Q2
    );
endinterface
`default_nettype wire

// File: rtl/synchronous_d_ff.sv
`default_nettype none
// ============================================================================
// Module      : synchronous_d_ff
// Description : Two-stage registered D flip-flop chain with synchronous,
//               active-high reset (RST_n keeps its legacy name).
// Revision    : 1.0 - initial release
// ============================================================================
module synchronous_d_ff #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  wire logic          CLK,
    input  wire logic          RST_n,
    synchronous_d_ff_if.slave  bus
);

    logic [WIDTH-1:0] r_q1;
    logic [WIDTH-1:0] r_q2;

    // RST_n is asserted high; it only acts on a rising edge, never asynchronously.
    always_ff @(posedge CLK) begin
        if (RST_n) begin
            r_q1 <= RESET_VALUE;
            r_q2 <= RESET_VALUE;
        end else begin
            r_q1 <= bus.D;
            r_q2 <= r_q1;
        end
    end

    assign bus.Q1 = r_q1;
    assign bus.Q2 = r_q2;

endmodule
`default_nettype wire

// File: tb/tb_synchronous_d_ff.sv
`default_nettype none
// ============================================================================
// Module      : tb_synchronous_d_ff
// Description : Self-checking bench for synchronous_d_ff (WIDTH=1 and WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_synchronous_d_ff;

    localparam logic [7:0] c_RV8 = 8'hA5;

    logic clk;
    logic rst1;
    logic rst8;
    int   total;
    int   bad;

    synchronous_d_ff_if #(.WIDTH(1)) bus1 ();
    synchronous_d_ff_if #(.WIDTH(8)) bus8 ();

    synchronous_d_ff #(.WIDTH(1), .RESET_VALUE(1'b0)) u_dut1 (
        .CLK   (clk),
        .RST_n (rst1),
        .bus   (bus1)
    );

    synchronous_d_ff #(.WIDTH(8), .RESET_VALUE(c_RV8)) u_dut8 (
        .CLK   (clk),
        .RST_n (rst8),
        .bus   (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Directed timeline is offset by 20 so a reset phase precedes it.
    task automatic at(input longint t);
        longint now_t;
        now_t = longint'($time);
        if (20 + t > now_t) #(20 + t - now_t);
    endtask

    logic       h_d1[$];
    logic       h_r1[$];
    logic [7:0] h_d8[$];
    logic       h_r8[$];

    initial begin
        int         n;
        logic       e1_q1, e1_q2;
        logic [7:0] e8_q1, e8_q2;
        total = 0;
        bad   = 0;

        // Reset phase: edges at 5 and 15 with D toggling
        rst1 = 1'b1; rst8 = 1'b1; bus1.D = 1'b1; bus8.D = 8'hFF;
        #6;
        chk("rst_q1", 8'(bus1.Q1), 8'h00);
        chk("rst_q2", 8'(bus1.Q2), 8'h00);
        chk("rst8_q1", bus8.Q1, c_RV8);
        chk("rst8_q2", bus8.Q2, c_RV8);
        bus1.D = 1'b0; #3; bus1.D = 1'b1; #7;
        chk("rst_hold_q1", 8'(bus1.Q1), 8'h00);
        chk("rst_hold_q2", 8'(bus1.Q2), 8'h00);

        // Data capture
        at(0);  rst1 = 1'b0; bus1.D = 1'b1;
        at(6);  chk("cap5_q1", 8'(bus1.Q1), 8'h01); chk("cap5_q2", 8'(bus1.Q2), 8'h00);
        at(11); bus1.D = 1'b0;
        at(16); chk("cap15_q1", 8'(bus1.Q1), 8'h00); chk("cap15_q2", 8'(bus1.Q2), 8'h01);
        at(23); bus1.D = 1'b1;
        at(26); chk("cap25_q1", 8'(bus1.Q1), 8'h01); chk("cap25_q2", 8'(bus1.Q2), 8'h00);
        at(36); chk("cap35_q2", 8'(bus1.Q2), 8'h01);

        // Synchronous assertion
        rst1 = 1'b1;
        at(40); chk("sa_hold_q1", 8'(bus1.Q1), 8'h01); chk("sa_hold_q2", 8'(bus1.Q2), 8'h01);
        at(46); chk("sa45_q1", 8'(bus1.Q1), 8'h00); chk("sa45_q2", 8'(bus1.Q2), 8'h00);
        at(47); bus1.D = 1'b0;
        at(56); chk("sa55_q1", 8'(bus1.Q1), 8'h00);
        at(59); bus1.D = 1'b1;
        at(66); chk("sa65_q1", 8'(bus1.Q1), 8'h00); chk("sa65_q2", 8'(bus1.Q2), 8'h00);

        // Synchronous release and mid-cycle glitch
        at(72); rst1 = 1'b0; bus1.D = 1'b1;
        at(76); chk("rel75_q1", 8'(bus1.Q1), 8'h01); chk("rel75_q2", 8'(bus1.Q2), 8'h00);
        at(81); rst1 = 1'b1;
        at(83); chk("glitch_q1", 8'(bus1.Q1), 8'h01); chk("glitch_q2", 8'(bus1.Q2), 8'h00);
        at(84); rst1 = 1'b0;
        at(86); chk("rel85_q1", 8'(bus1.Q1), 8'h01); chk("rel85_q2", 8'(bus1.Q2), 8'h01);

        // WIDTH=8 instance
        chk("w8_rst_q1", bus8.Q1, c_RV8);
        at(88); rst8 = 1'b0; bus8.D = 8'h3C;
        at(96); chk("w8_e1_q1", bus8.Q1, 8'h3C); chk("w8_e1_q2", bus8.Q2, c_RV8);
        bus8.D = 8'hC3;
        at(106); chk("w8_e2_q1", bus8.Q1, 8'hC3); chk("w8_e2_q2", bus8.Q2, 8'h3C);
        at(116); chk("w8_e3_q2", bus8.Q2, 8'hC3);

        // Randomized phase against a history-based model
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            bus1.D = 1'($urandom);
            bus8.D = 8'($urandom);
            rst1   = (i == 0) || ($urandom_range(0, 7) == 0);
            rst8   = (i == 0) || ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) begin
                #1 rst1 = ~rst1; rst8 = ~rst8;
                #1 rst1 = ~rst1; rst8 = ~rst8;
            end
            @(posedge clk);
            h_d1.push_back(bus1.D); h_r1.push_back(rst1);
            h_d8.push_back(bus8.D); h_r8.push_back(rst8);
            #1;
            n = h_d1.size() - 1;
            e1_q1 = h_r1[n] ? 1'b0 : h_d1[n];
            e1_q2 = (h_r1[n] || (n > 0 && h_r1[n-1])) ? 1'b0 : h_d1[n-1];
            e8_q1 = h_r8[n] ? c_RV8 : h_d8[n];
            e8_q2 = (h_r8[n] || (n > 0 && h_r8[n-1])) ? c_RV8 : h_d8[n-1];
            chk("rnd1_q1", 8'(bus1.Q1), 8'(e1_q1));
            chk("rnd1_q2", 8'(bus1.Q2), 8'(e1_q2));
            chk("rnd8_q1", bus8.Q1, e8_q1);
            chk("rnd8_q2", bus8.Q2, e8_q2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
